// File: rtl/bus_pkg.sv
// Shared constants for the miniRV data-bus bridge: peripheral map and 7-segment decode.
package bus_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
  localparam logic [11:0] OFF_TUBE    = 12'h000;
  localparam logic [11:0] OFF_LED     = 12'h060;
  localparam logic [11:0] OFF_SW      = 12'h070;

  // Active-low {DP,G,F,E,D,C,B,A}; DP is off for every glyph.
  function automatic logic [7:0] hexdec(input logic [3:0] nib);
    logic [7:0] seg;
    seg = 8'hFF;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/dbus_bridge_if.sv
// Core data-bus and DRAM signals; master is the core/DRAM side, slave is the bridge.
interface dbus_bridge_if #(
  parameter int unsigned DRAM_AW = 14
);
  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_wdata;
  logic               cpu_we;
  logic [31:0]        cpu_rdata;
  logic [DRAM_AW-1:0] dram_addr;
  logic [31:0]        dram_wdata;
  logic               dram_we;
  logic [31:0]        dram_rdata;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, dram_rdata,
    input  cpu_rdata, dram_addr, dram_wdata, dram_we
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, dram_rdata,
    output cpu_rdata, dram_addr, dram_wdata, dram_we
  );
endinterface

// File: rtl/seg7_scan.sv
// 8-digit multiplexed 7-segment scan: SCAN_DIV clocks per digit, registered active-low outputs.
module seg7_scan
  import bus_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_tube,
  output logic [7:0]  o_dig_en,
  output logic [7:0]  o_dn_seg
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);

  logic [CntW-1:0] r_div_cnt;
  logic [2:0]      r_idx;
  logic            w_wrap;

  assign w_wrap = (r_div_cnt == CntW'(SCAN_DIV - 1));

  // Outputs follow the current idx, so a digit change appears one edge after idx moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
      o_dig_en  <= 8'hFE;
      o_dn_seg  <= 8'hC0;
    end else begin
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_idx     <= r_idx + 3'd1;
      end else begin
        r_div_cnt <= r_div_cnt + CntW'(1);
      end
      o_dig_en <= ~(8'b1 << r_idx);
      o_dn_seg <= hexdec(i_tube[{r_idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: rtl/dbus_bridge.sv
// Data-bus responder for the single-cycle miniRV core: routes accesses to DRAM or peripherals.
module dbus_bridge
  import bus_pkg::*;
#(
  parameter int unsigned DRAM_AW     = 14,
  parameter int unsigned SCAN_DIV    = 20000,
  parameter logic [31:0] PERIPH_BASE = bus_pkg::PERIPH_BASE
) (
  input  logic         clk,
  input  logic         rst_n,
  dbus_bridge_if.slave bus,
  input  logic [23:0]  sw,
  output logic [23:0]  led,
  output logic [7:0]   dig_en,
  output logic [7:0]   dn_seg
);

  logic [31:0] r_tube;
  logic [23:0] r_led;
  logic [23:0] r_sw_meta;
  logic [23:0] r_sw_sync;

  logic        w_periph;
  logic        w_sel_tube;
  logic        w_sel_led;
  logic        w_sel_sw;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_periph   = (bus.cpu_addr[31:12] == PERIPH_BASE[31:12]);
  assign w_sel_tube = w_periph && (bus.cpu_addr[11:2] == OFF_TUBE[11:2]);
  assign w_sel_led  = w_periph && (bus.cpu_addr[11:2] == OFF_LED[11:2]);
  assign w_sel_sw   = w_periph && (bus.cpu_addr[11:2] == OFF_SW[11:2]);

  // Byte offset bits carry no meaning: accesses are full-word only.
  assign w_unused_addr = ^bus.cpu_addr[1:0];

  assign bus.dram_addr  = bus.cpu_addr[DRAM_AW+1:2];
  assign bus.dram_wdata = bus.cpu_wdata;
  assign bus.dram_we    = bus.cpu_we & ~w_periph;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_tube    <= '0;
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      if (bus.cpu_we && w_sel_tube) r_tube <= bus.cpu_wdata;
      if (bus.cpu_we && w_sel_led)  r_led  <= bus.cpu_wdata[23:0];
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_comb begin
    w_rdata = bus.dram_rdata;
    if (w_periph) begin
      w_rdata = '0;
      if (w_sel_tube) w_rdata = r_tube;
      if (w_sel_led)  w_rdata = {8'h00, r_led};
      if (w_sel_sw)   w_rdata = {8'h00, r_sw_sync};
    end
  end

  assign bus.cpu_rdata = w_rdata;
  assign led           = r_led;

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst     (rst_n),
    .i_tube  (r_tube),
    .o_dig_en(dig_en),
    .o_dn_seg(dn_seg)
  );

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
- Data-bus responder for the single-cycle miniRV core: the other end of the core's `alu_c` / `rf_rd2` / `dram_we` / `dram_rd` data interface.
- Decodes each core access and routes it to the external DRAM or to on-board memory-mapped peripherals.
- Peripherals: LEDs, switches and an 8-digit 7-segment display with a built-in scan engine.
- Read data returns in the same cycle, because the core is single-cycle.

Parameters:
- DRAM_AW, 14: DRAM word-address width; `dram_addr = cpu_addr[DRAM_AW+1:2]`.
- SCAN_DIV, 20000: clocks per digit in the display scan; legal range ≥ 2.
- PERIPH_BASE, 32'hFFFF_F000: base of the 4 KiB peripheral window.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1); the name is kept for consistency with the core's port naming.
- cpu_addr  in  32  byte address from the core (ALU result).
- cpu_wdata  in  32  store data from the core (rs2).
- cpu_we  in  1  store strobe from the core.
- cpu_rdata  out  32  load data to the core; combinational.
- dram_addr  out  DRAM_AW  DRAM word address.
- dram_wdata  out  32  DRAM write data (pass-through of `cpu_wdata`).
- dram_we  out  1  DRAM write enable.
- dram_rdata  in  32  DRAM read data (asynchronous read).
- sw  in  24  board switches; asynchronous to clk.
- led  out  24  board LEDs; registered.
- dig_en  out  8  digit enables, active-low, one-hot-zero; registered.
- dn_seg  out  8  segments {DP,G,F,E,D,C,B,A}, active-low; registered.

Behaviour:
- Decode:
  - periph = (`cpu_addr[31:12]` == `PERIPH_BASE[31:12]`); everything else is DRAM.
  - Peripheral register select uses `cpu_addr[11:2]`; `cpu_addr[1:0]` are ignored. Accesses are full-word only.
- Peripheral register offsets:
  - 0x000: TUBE, RW, 32 bits, 8 hex digits; digit i = bits [4i+3:4i].
  - 0x060: LED, RW, low 24 bits; bits [31:24] are written but ignored and read back 0.
  - 0x070: SW, RO, synchronized switches, zero-extended.
  - Any other offset in the window: reads 0; writes ignored.
- DRAM path:
  - `dram_we` = `cpu_we` & !periph (combinational).
  - `dram_addr` and `dram_wdata` pass through unconditionally.
- Read path: `cpu_rdata` = periph ? selected register : `dram_rdata`. Zero added latency; no handshake, the core never stalls.
- Writes: a register updates on the rising edge where `cpu_we`=1 and its offset is selected. A read of the same register in the following cycle returns the new value.
- LED: `led` is the LED register bits [23:0] directly, so it is visible the cycle after the write edge.
- Switch synchronizer: 2-flop; a `sw` change is visible on a read 2 edges later.
- Scan engine:
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap edge, `idx` (3 bits) increments 0→7→0.
  - Each edge: `dig_en` <= ~(8'b1 << idx); `dn_seg` <= hexdec(TUBE[4·idx+3 : 4·idx]), with DP always off (1).
  - Output latency is 1 cycle from any `idx` or TUBE change.
- hexdec (active-low, {DP..A}):
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
  - 8→80, 9→90, A→88, B→83, C→C6, D→A1, E→86, F→8E
- Reset (async assert, values held while asserted):
  - TUBE=0, LED=0, sync flops=0, `div_cnt`=0, `idx`=0.
  - Outputs: `led`=0, `dig_en`=8'hFE, `dn_seg`=8'hC0.
- Reset mid-scan or mid-store: state is lost immediately; a store coincident with assertion is discarded.
- Deassertion: scanning restarts at digit 0 with a full SCAN_DIV dwell.
- A TUBE write during a dwell is shown on the current digit from the next cycle; there is no tearing beyond that 1 cycle.

Decomposition:
- Shared package `bus_pkg`:
  - Constants PERIPH_BASE, OFF_TUBE=12'h000, OFF_LED=12'h060, OFF_SW=12'h070.
  - Function or constant table for hexdec.
- One sub-module `seg7_scan`: `div_cnt`, `idx`, hexdec and the registered `dig_en`/`dn_seg`, taking TUBE as input.
- Decode, registers, synchronizer and read mux stay in `dbus_bridge`.

Test Plan:
- Reset: assert `rst_n`=1 mid-run with TUBE=0x12345678 → `led`=0, `dig_en`=FE, `dn_seg`=C0 immediately; TUBE reads back 0 after release.
- LED: store 0xAB_CDEF12 to 0xFFFF_F060 → `led`=0xCDEF12 next cycle; `dram_we` stays 0; readback 0x00CDEF12.
- DRAM routing:
  - Store 0xDEADBEEF to 0x0000_0010 → `dram_we`=1 that cycle, `dram_addr`=4.
  - Load with `dram_rdata`=0x55 → `cpu_rdata`=0x55 same cycle.
  - Store to 0xFFFF_F100 → `dram_we`=0; load from it returns 0.
- Switch: set `sw`=0x00A5A5 → reads of 0xFFFF_F070 return the old value for 1 edge, then 0x000000A5A5 from the 2nd edge on.
- Scan (SCAN_DIV=4): TUBE=0x0000_00F1 → `dig_en` sequence FE,FD,FB..7F, each held 4 cycles; `dn_seg` F9 on digit 0, 8E on digit 1, C0 elsewhere; wraps to FE after 32 cycles.
- Mid-dwell TUBE write: write TUBE=0x8 while digit 0 is active → `dn_seg`=80 exactly 1 cycle after the write edge.
